// File: rtl/state_timer_if.sv
// -----------------------------------------------------------------------------
// state_timer_if
// Purpose : Groups the controller-side signals of the state timer into one bundle.
// Signals :
//   present_state [3:0]       controller state code (master -> slave)
//   tload         [WIDTH-1:0] interval from the time selector (master -> slave)
//   hold                      emergency pause (master -> slave)
//   remaining     [WIDTH-1:0] current count value (slave -> master)
//   busy                      high while counting (slave -> master)
//   done                      one-cycle expiry pulse (slave -> master)
// Modports: master = controller/testbench side, slave = state_timer side.
// -----------------------------------------------------------------------------
interface state_timer_if #(
  parameter int WIDTH = 19
);
  logic [3:0]       present_state;
  logic [WIDTH-1:0] tload;
  logic             hold;
  logic [WIDTH-1:0] remaining;
  logic             busy;
  logic             done;

  modport master (
    output present_state,
    output tload,
    output hold,
    input  remaining,
    input  busy,
    input  done
  );

  modport slave (
    input  present_state,
    input  tload,
    input  hold,
    output remaining,
    output busy,
    output done
  );
endinterface

// File: rtl/state_timer.sv
// -----------------------------------------------------------------------------
// state_timer
// Purpose : Countdown stage after the time selector. Arms a new countdown on
//           every present_state change, decrements once per prescaled tick and
//           emits a one-cycle done pulse on expiry.
// Ports   :
//   clk  - system clock, rising-edge
//   rst  - asynchronous, active-high reset
//   bus  - state_timer_if.slave (present_state, tload, hold in;
//          remaining, busy, done out; all outputs registered)
// -----------------------------------------------------------------------------
module state_timer #(
  parameter int WIDTH    = 19,
  parameter int PRESCALE = 50000,
  parameter int PW       = 16
) (
  input logic           clk,
  input logic           rst,
  state_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_t;

  localparam logic [PW-1:0] LP_LAST_TICK = PW'(PRESCALE - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_prev_state;
  logic [PW-1:0]    r_prescaler;
  logic [PW-1:0]    w_prescaler_nxt;
  logic [WIDTH-1:0] r_remaining;
  logic [WIDTH-1:0] w_remaining_nxt;
  logic             r_busy;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_change;

  // A state change is judged against last cycle's code; prev resets to 0 so a
  // non-zero code after reset release counts as a change.
  assign w_change = (bus.present_state != r_prev_state);

  // Next-state, next-count and done-pulse decision
  always_comb begin
    w_state_nxt     = r_state;
    w_prescaler_nxt = r_prescaler;
    w_remaining_nxt = r_remaining;
    w_done_nxt      = 1'b0;
    if (w_change) begin
      // A load wins over any tick landing in the same cycle.
      w_prescaler_nxt = {PW{1'b0}};
      if (bus.tload != {WIDTH{1'b0}}) begin
        w_remaining_nxt = bus.tload;
        w_state_nxt     = RUN;
      end else begin
        w_remaining_nxt = {WIDTH{1'b0}};
        w_state_nxt     = IDLE;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (bus.hold) begin
            w_prescaler_nxt = r_prescaler;
          end else if (r_prescaler == LP_LAST_TICK) begin
            w_prescaler_nxt = {PW{1'b0}};
            if (r_remaining > WIDTH'(1)) begin
              w_remaining_nxt = r_remaining - WIDTH'(1);
            end else if (r_remaining == WIDTH'(1)) begin
              w_remaining_nxt = {WIDTH{1'b0}};
              w_state_nxt     = EXPIRED;
              w_done_nxt      = 1'b1;
            end else begin
              // Unreachable guard: never decrement below zero.
              w_remaining_nxt = {WIDTH{1'b0}};
              w_state_nxt     = IDLE;
            end
          end else begin
            w_prescaler_nxt = r_prescaler + PW'(1);
          end
        end
        EXPIRED: begin
          w_remaining_nxt = {WIDTH{1'b0}};
        end
        IDLE: begin
          w_prescaler_nxt = r_prescaler;
        end
        default: begin
          w_state_nxt     = IDLE;
          w_prescaler_nxt = {PW{1'b0}};
          w_remaining_nxt = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prev_state <= 4'b0000;
      r_prescaler  <= {PW{1'b0}};
      r_remaining  <= {WIDTH{1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_state <= bus.present_state;
      r_prescaler  <= w_prescaler_nxt;
      r_remaining  <= w_remaining_nxt;
      r_busy       <= (w_state_nxt == RUN);
      r_done       <= w_done_nxt;
    end
  end

  assign bus.remaining = r_remaining;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_state_timer.sv
// -----------------------------------------------------------------------------
// tb_state_timer
// Purpose : Directed self-checking bench for state_timer with PRESCALE=4.
//           Inputs change and outputs are sampled 1 time unit after each
//           rising edge.
// -----------------------------------------------------------------------------
module tb_state_timer;
  localparam int WIDTH    = 19;
  localparam int PRESCALE = 4;
  localparam int PW       = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  state_timer_if #(.WIDTH(WIDTH)) st_if ();

  state_timer #(
    .WIDTH(WIDTH),
    .PRESCALE(PRESCALE),
    .PW(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(st_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    st_if.present_state = 4'b0000;
    st_if.tload = '0;
    st_if.hold = 1'b0;
    tick(2);
    n_checks++;
    if (st_if.remaining !== 19'd0 || st_if.busy !== 1'b0 || st_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: rem=%0d busy=%0b done=%0b expected 0/0/0",
               st_if.remaining, st_if.busy, st_if.done);
    end
    rst = 1'b0;
    tick(2);
    n_checks++;
    if (st_if.remaining !== 19'd0 || st_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: rem=%0d busy=%0b expected 0/0", st_if.remaining, st_if.busy);
    end
  endtask

  task automatic test_basic();
    st_if.present_state = 4'b0010;
    st_if.tload = 19'd3;
    tick(1);
    n_checks++;
    if (st_if.remaining !== 19'd3 || st_if.busy !== 1'b1 || st_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_load: rem=%0d busy=%0b done=%0b expected 3/1/0",
               st_if.remaining, st_if.busy, st_if.done);
    end
    tick(3);
    n_checks++;
    if (st_if.remaining !== 19'd3) begin
      n_fail++;
      $display("FAIL basic_plus3: rem=%0d expected 3", st_if.remaining);
    end
    tick(1);
    n_checks++;
    if (st_if.remaining !== 19'd2) begin
      n_fail++;
      $display("FAIL basic_plus4: rem=%0d expected 2", st_if.remaining);
    end
    tick(4);
    n_checks++;
    if (st_if.remaining !== 19'd1 || st_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_plus8: rem=%0d done=%0b expected 1/0", st_if.remaining, st_if.done);
    end
    tick(4);
    n_checks++;
    if (st_if.remaining !== 19'd0 || st_if.done !== 1'b1 || st_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_expire: rem=%0d done=%0b busy=%0b expected 0/1/0",
               st_if.remaining, st_if.done, st_if.busy);
    end
    tick(1);
    n_checks++;
    if (st_if.done !== 1'b0 || st_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pulse_width: done=%0b busy=%0b expected 0/0", st_if.done, st_if.busy);
    end
    tick(8);
    n_checks++;
    if (st_if.done !== 1'b0 || st_if.remaining !== 19'd0) begin
      n_fail++;
      $display("FAIL basic_expired_stays: done=%0b rem=%0d expected 0/0", st_if.done, st_if.remaining);
    end
  endtask

  task automatic test_zero();
    int seen_done;
    seen_done = 0;
    st_if.present_state = 4'b0110;
    st_if.tload = 19'd0;
    tick(1);
    n_checks++;
    if (st_if.remaining !== 19'd0 || st_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_load: rem=%0d busy=%0b expected 0/0", st_if.remaining, st_if.busy);
    end
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (st_if.done === 1'b1) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_fail++;
      $display("FAIL zero_no_done: pulses=%0d expected 0", seen_done);
    end
  endtask

  task automatic test_reload();
    int pulses;
    int at;
    pulses = 0;
    at = -1;
    st_if.present_state = 4'b0010;
    st_if.tload = 19'd5;
    tick(1);
    tick(7);
    n_checks++;
    if (st_if.remaining !== 19'd4) begin
      n_fail++;
      $display("FAIL reload_before: rem=%0d expected 4", st_if.remaining);
    end
    st_if.present_state = 4'b0011;
    st_if.tload = 19'd2;
    tick(1);
    n_checks++;
    if (st_if.remaining !== 19'd2 || st_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_load: rem=%0d busy=%0b expected 2/1", st_if.remaining, st_if.busy);
    end
    for (int i = 1; i <= 14; i++) begin
      tick(1);
      if (st_if.done === 1'b1) begin
        pulses++;
        at = i;
      end
    end
    n_checks++;
    if (pulses !== 1 || at !== 8) begin
      n_fail++;
      $display("FAIL reload_done: pulses=%0d at=%0d expected 1 at 8", pulses, at);
    end
  endtask

  task automatic test_hold();
    int pulses;
    int at;
    pulses = 0;
    at = -1;
    st_if.present_state = 4'b0100;
    st_if.tload = 19'd2;
    tick(1);
    for (int i = 1; i <= 24; i++) begin
      tick(1);
      if (i == 13) begin
        n_checks++;
        if (st_if.remaining !== 19'd2 || st_if.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL hold_frozen: rem=%0d busy=%0b expected 2/1", st_if.remaining, st_if.busy);
        end
      end
      if (st_if.done === 1'b1) begin
        pulses++;
        at = i;
      end
      if (i == 3) st_if.hold = 1'b1;
      if (i == 13) st_if.hold = 1'b0;
    end
    n_checks++;
    if (pulses !== 1 || at !== 18) begin
      n_fail++;
      $display("FAIL hold_done: pulses=%0d at=%0d expected 1 at 18", pulses, at);
    end
  endtask

  task automatic test_collision();
    int pulses;
    pulses = 0;
    st_if.present_state = 4'b0101;
    st_if.tload = 19'd1;
    tick(1);
    tick(3);
    st_if.present_state = 4'b0111;
    st_if.tload = 19'd6;
    tick(1);
    n_checks++;
    if (st_if.remaining !== 19'd6 || st_if.done !== 1'b0 || st_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_load: rem=%0d done=%0b busy=%0b expected 6/0/1",
               st_if.remaining, st_if.done, st_if.busy);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (st_if.done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || st_if.remaining !== 19'd5) begin
      n_fail++;
      $display("FAIL collision_after: pulses=%0d rem=%0d expected 0/5", pulses, st_if.remaining);
    end
  endtask

  task automatic test_max_load();
    st_if.present_state = 4'b1001;
    st_if.tload = 19'h7FFFF;
    tick(1);
    n_checks++;
    if (st_if.remaining !== 19'h7FFFF) begin
      n_fail++;
      $display("FAIL max_load: rem=%0h expected 7ffff", st_if.remaining);
    end
    tick(4);
    n_checks++;
    if (st_if.remaining !== 19'h7FFFE) begin
      n_fail++;
      $display("FAIL max_dec: rem=%0h expected 7fffe", st_if.remaining);
    end
  endtask

  task automatic test_async_reset();
    int pulses;
    pulses = 0;
    st_if.present_state = 4'b1000;
    st_if.tload = 19'd5;
    tick(1);
    tick(4);
    n_checks++;
    if (st_if.remaining !== 19'd4) begin
      n_fail++;
      $display("FAIL areset_pre: rem=%0d expected 4", st_if.remaining);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (st_if.remaining !== 19'd0 || st_if.busy !== 1'b0 || st_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: rem=%0d busy=%0b done=%0b expected 0/0/0",
               st_if.remaining, st_if.busy, st_if.done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick(1);
    n_checks++;
    if (st_if.remaining !== 19'd5 || st_if.done !== 1'b0 || st_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_reload: rem=%0d done=%0b busy=%0b expected 5/0/1",
               st_if.remaining, st_if.done, st_if.busy);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (st_if.done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL areset_no_pulse: pulses=%0d expected 0", pulses);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_zero();
    test_reload();
    test_hold();
    test_collision();
    test_max_load();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/state_timer.md
Name: state_timer

Overview:
- Countdown stage directly downstream of the time selector in the train controller.
- Takes the selected 19-bit interval and the controller's 4-bit present_state.
- Arms a new countdown whenever present_state changes, decrements once per prescaled tick, and emits a one-cycle done pulse that the state machine uses to advance.
- Exposes the remaining count for display and debug.

Parameters:
WIDTH, 19, bit width of the interval and remaining counter; matches the selector output width
PRESCALE, 50000, clock cycles per countdown tick (1 ms at 50 MHz); must be >= 2
PW, 16, prescaler counter width; must satisfy 2^PW >= PRESCALE

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
present_state  input  4  controller state code
tload  input  WIDTH  interval from the selector, valid in the same cycle as present_state
hold  input  1  freezes the prescaler and counter while high (emergency pause)
remaining  output  WIDTH  current count value
busy  output  1  high while in RUN
done  output  1  one-cycle pulse on expiry

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- Reset values: remaining=0, busy=0, done=0, prescaler=0, prev_state=4'b0000, FSM=IDLE.
- Change detect: prev_state registers present_state every cycle. A change is present_state != prev_state, evaluated combinationally before the edge.
- After reset release, a non-zero present_state counts as a change on the first edge.
- FSM states: IDLE, RUN, EXPIRED.
- Change, with tload != 0, from any state:
  - At the edge: remaining<=tload, prescaler<=0, FSM<=RUN, done<=0.
  - busy goes high the next cycle.
- Change, with tload == 0: remaining<=0, FSM<=IDLE, done stays 0. The selector's default 0 therefore never produces a done pulse.
- RUN, hold=0:
  - prescaler increments each edge.
  - When prescaler==PRESCALE-1: prescaler<=0 and remaining<=remaining-1.
  - If that decrement takes remaining from 1 to 0: FSM<=EXPIRED and done<=1 for exactly one cycle.
- RUN, hold=1: prescaler and remaining hold their values; busy stays 1.
- EXPIRED: remaining=0, busy=0. The block stays here until the next change. done is not repeated.
- IDLE: nothing counts; busy=0.
- Latency: after a load at edge E0, remaining decrements at E0+PRESCALE, E0+2*PRESCALE, ….
  - done is high in the cycle after edge E0+tload*PRESCALE.
  - Total = tload*PRESCALE cycles from load to the done edge.
- Simultaneous events:
  - Change in the same cycle as the final tick: the load wins, done is not asserted, and the new interval starts.
  - Change while hold=1: the load still happens. Counting starts once hold drops.
  - hold=1 on the cycle the final tick would occur: nothing happens until hold=0.
- Arithmetic: remaining never underflows. Decrement occurs only in RUN with remaining >= 1. Max tload = 2^WIDTH-1, with no wrap.
- Reset mid-count: all registers return to their reset values immediately (asynchronous). No done pulse is produced.
- done, busy and remaining are all registered outputs; none is driven combinationally from inputs.

Test Plan:
- Basic countdown (PRESCALE=4): reset, then present_state 0000→0010 with tload=3. Expect remaining=3 after the load edge, then 2, 1, 0 at +4, +8, +12 cycles. done is high one cycle after +12, busy falls at the same point, and FSM=EXPIRED.
- Zero interval: present_state→0110 with tload=0. Expect remaining=0, busy=0, and done never asserted for 50 cycles.
- Reload mid-count: load tload=5 in state 0010. After 7 cycles, switch to state 0011 with tload=2. Expect remaining=2 and the prescaler reset at that edge. done occurs 8 cycles later, and only once.
- Hold: tload=2. Assert hold for 10 cycles starting at cycle 3. Expect done at load+8+10 cycles and remaining frozen at 2 during hold.
- Collision: tload=1, and change state exactly at the cycle where prescaler==PRESCALE-1. Expect no done and remaining=new tload.
- Async reset: assert rst mid-count with remaining=4, between clock edges. Expect remaining=0, busy=0 and done=0 immediately, with no pulse after release while present_state is unchanged and non-zero beyond one reload.
